// File: rtl/tfd_frame_sequencer.sv
// rtl/tfd_frame_sequencer.sv - issues one TFD frame of strided element requests under an outstanding window
// Optional abort support is compiled in with TFD_SEQ_ABORT_EN.
`timescale 1ns/1ps
module tfd_frame_sequencer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH_WIDTH     = 16,
    parameter int STRIDE_WIDTH    = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
    input  logic [DEPTH_WIDTH-1:0]  cfg_depth,
    input  logic [STRIDE_WIDTH-1:0] cfg_stride,
    input  logic                    cfg_start,
`ifdef TFD_SEQ_ABORT_EN
    input  logic                    abort,
    output logic                    aborted,
`endif
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic                    req_valid,
    output logic                    req_last,
    input  logic                    req_ready,
    input  logic                    rsp_valid,
    output logic                    busy,
    output logic                    done,
    output logic [DEPTH_WIDTH-1:0]  issued_count
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]              state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DEPTH_WIDTH-1:0]  depth_q;
    logic [DEPTH_WIDTH-1:0]  issued_q;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic [OUT_W-1:0]        outstanding_q;
    logic [OUT_W-1:0]        outstanding_nxt;
    logic                    abort_q;
    logic                    abort_in;
    logic                    hs;
    logic                    rsp_take;

`ifdef TFD_SEQ_ABORT_EN
    assign abort_in = abort;
    assign aborted  = (state == ST_DONE) && abort_q;
`else
    assign abort_in = 1'b0;
`endif

    // The window only gates assertion: while a request waits, outstanding can only fall.
    assign req_valid    = (state == ST_ISSUE) && (outstanding_q < OUT_MAX);
    assign req_last     = req_valid && (issued_q == depth_q - DEPTH_WIDTH'(1));
    assign req_addr     = addr_q;
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign issued_count = issued_q;

    assign hs       = req_valid && req_ready;
    assign rsp_take = rsp_valid && (outstanding_q != '0);

    always_comb begin
        outstanding_nxt = outstanding_q;
        if (hs && !rsp_take) begin
            outstanding_nxt = outstanding_q + OUT_W'(1);
        end else if (!hs && rsp_take) begin
            outstanding_nxt = outstanding_q - OUT_W'(1);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            depth_q       <= '0;
            issued_q      <= '0;
            stride_q      <= '0;
            outstanding_q <= '0;
            abort_q       <= 1'b0;
        end else begin
            outstanding_q <= outstanding_nxt;
            if (hs) begin
                issued_q <= issued_q + DEPTH_WIDTH'(1);
                addr_q   <= addr_q + ADDR_WIDTH'(stride_q);
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        addr_q        <= cfg_base_addr;
                        depth_q       <= cfg_depth;
                        stride_q      <= cfg_stride;
                        issued_q      <= '0;
                        outstanding_q <= '0;
                        abort_q       <= 1'b0;
                        state         <= (cfg_depth != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (abort_in) begin
                        abort_q <= 1'b1;
                    end
                    // A pending request is allowed to finish before an abort takes effect.
                    if (hs && (req_last || abort_in || abort_q)) begin
                        state <= ST_DRAIN;
                    end else if (abort_in && !req_valid) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_nxt == '0) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tfd_frame_sequencer.sv
// tb/tb_tfd_frame_sequencer.sv - table-driven directed bench for tfd_frame_sequencer
`timescale 1ns/1ps
module tb_tfd_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_depth;
    logic [7:0]  cfg_stride;
    logic        cfg_start;
    logic [31:0] req_addr;
    logic        req_valid;
    logic        req_last;
    logic        req_ready;
    logic        rsp_valid;
    logic        busy;
    logic        done;
    logic [15:0] issued_count;

    int n_chk = 0;
    int n_err = 0;

    tfd_frame_sequencer #(
        .ADDR_WIDTH(32), .DEPTH_WIDTH(16), .STRIDE_WIDTH(8), .MAX_OUTSTANDING(4)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rst_n),
        .cfg_base_addr(cfg_base_addr),
        .cfg_depth(cfg_depth),
        .cfg_stride(cfg_stride),
        .cfg_start(cfg_start),
        .req_addr(req_addr),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .busy(busy),
        .done(done),
        .issued_count(issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 ready always, 1 ready on odd cycles, 2 ready low for the first 5 cycles
    typedef struct {
        logic [31:0] base;
        logic [15:0] depth;
        logic [7:0]  stride;
        int          mode;
        int          lag;
        int          poke;
        int          exp_count;
        logic [31:0] exp_last;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int          hs;
        int          obs;
        int          done_obs;
        int          q[$];
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [31:0] last_addr;
        hs = 0; done_obs = 0; prev_stall = 1'b0; prev_addr = '0; last_addr = '0;
        cfg_base_addr = v.base;
        cfg_depth     = v.depth;
        cfg_stride    = v.stride;
        cfg_start     = 1'b1;
        step();
        cfg_start = 1'b0;
        obs = 1;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        while (obs < 200 && done_obs == 0) begin
            if (done) begin
                done_obs  = obs;
                req_ready = 1'b0;
                rsp_valid = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, req_valid}, 32'd1);
                    chk("hold_addr", req_addr, prev_addr);
                end
                case (v.mode)
                    1:       req_ready = (obs % 2 == 1);
                    2:       req_ready = (obs > 5);
                    default: req_ready = 1'b1;
                endcase
                if (v.poke != 0 && obs == 2) begin
                    cfg_start     = 1'b1;
                    cfg_base_addr = 32'hDEAD_0000;
                    cfg_depth     = 16'd7;
                end
                rsp_valid = 1'b0;
                if (q.size() > 0 && q[0] <= obs) begin
                    void'(q.pop_front());
                    rsp_valid = 1'b1;
                end
                if (req_valid && req_ready) begin
                    chk("req_addr", req_addr, v.base + 32'(hs) * 32'(v.stride));
                    chk("req_last", {31'd0, req_last}, {31'd0, hs == int'(v.depth) - 1});
                    last_addr = req_addr;
                    q.push_back(obs + v.lag);
                    hs++;
                end
                prev_stall = req_valid && !req_ready;
                prev_addr  = req_addr;
            end
            step();
            cfg_start = 1'b0;
            obs++;
        end
        chk("done_cycle", 32'(done_obs), 32'(v.exp_done));
        chk("handshakes", 32'(hs), 32'(v.exp_count));
        chk("last_addr", last_addr, v.exp_last);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("issued_count", {16'd0, issued_count}, 32'(v.exp_count));
    endtask

    initial begin
        int hs;
        int budget;
        vecs[0] = '{32'h0000_1000, 16'd4, 8'd8,    0, 1, 0, 4, 32'h0000_1018, 6};
        vecs[1] = '{32'hFFFF_FFF8, 16'd4, 8'd4,    2, 1, 0, 4, 32'h0000_0004, 11};
        vecs[2] = '{32'h0000_2000, 16'd1, 8'h10,   0, 1, 0, 1, 32'h0000_2000, 3};
        vecs[3] = '{32'h0000_0040, 16'd5, 8'd3,    1, 2, 0, 5, 32'h0000_004C, 12};
        vecs[4] = '{32'h0000_3000, 16'd0, 8'd4,    0, 1, 0, 0, 32'h0000_0000, 1};
        vecs[5] = '{32'h0000_0500, 16'd3, 8'd2,    0, 1, 1, 3, 32'h0000_0504, 5};

        rst_n = 1'b0; cfg_base_addr = '0; cfg_depth = '0; cfg_stride = '0;
        cfg_start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        repeat (3) step();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_req_addr", req_addr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_issued", {16'd0, issued_count}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
            step();
        end

        // outstanding window: depth 8 with no responses
        cfg_base_addr = 32'h0; cfg_depth = 16'd8; cfg_stride = 8'd1; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        req_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_valid) hs++;
            step();
        end
        chk("window_hs", 32'(hs), 32'd4);
        chk("window_closed", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_valid) hs++;
            step();
        end
        chk("window_one_more", 32'(hs), 32'd1);
        chk("window_reclosed", {31'd0, req_valid}, 32'd0);
        chk("window_issued", {16'd0, issued_count}, 32'd5);
        rsp_valid = 1'b1;
        budget = 0;
        while (!done && budget < 60) begin
            if (req_valid) hs++;
            step();
            budget++;
        end
        chk("window_done", {31'd0, done}, 32'd1);
        chk("window_total", 32'(hs + 4), 32'd8);
        chk("window_final_issued", {16'd0, issued_count}, 32'd8);
        rsp_valid = 1'b0; req_ready = 1'b0;
        step();
        chk("window_idle", {31'd0, busy}, 32'd0);
        step();

        // asynchronous reset in the middle of ISSUE
        cfg_base_addr = 32'h100; cfg_depth = 16'd6; cfg_stride = 8'd4; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        req_ready = 1'b1;
        step();
        step();
        chk("mid_issued", {16'd0, issued_count}, 32'd2);
        req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, req_valid}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_issued", {16'd0, issued_count}, 32'd0);
        chk("async_addr", req_addr, 32'd0);
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) hs++;
            step();
        end
        rst_n = 1'b1;
        step();
        if (done) hs++;
        chk("no_done_on_reset", 32'(hs), 32'd0);
        run_frame(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
